lcd_mode_display: RTL and testbench
===================================

# lcd_mode_display

Text-LCD controller that sits downstream of the mode state machine in the top-level watch application. It takes the current 2-bit mode and drives a 16x2 HD44780-compatible character LCD through its 8-bit parallel bus. After reset it runs the power-up init sequence, writes the mode banner, and then rewrites both lines whenever the mode changes. It replaces the free-running `lcd_e` tie-off in the top level and consumes the same 1 kHz system clock.

## Interface
- `INIT_WAIT`, default 20: power-up wait in clocks before the first command (20 ms at 1 kHz).
- `CLR_WAIT`, default 2: extra idle clocks after the clear-display command.
- `clk`  input  1  1 kHz system clock; all logic is on the rising edge.
- `rst`  input  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high).
- `mode_sel`  input  2  current application mode: 0 watch, 1 stopwatch, 2 alarm, 3 treated as 0.
- `busy`  output  1  high while init or refresh is in progress.
- `lcd_e`  output  1  LCD enable strobe.
- `lcd_rs`  output  1  0 = command, 1 = data.
- `lcd_rw`  output  1  constant 0 (write only).
- `lcd_data`  output  8  LCD data bus.

## Operation
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `busy`=1, state=PWR_WAIT, wait counter=0, displayed-mode register=0, pending flag=0.
- Byte write micro-sequence, 3 clocks per byte:
  - SETUP: `lcd_rs` and `lcd_data` are driven; `lcd_e`=0.
  - STROBE: `lcd_e`=1.
  - HOLD: `lcd_e`=0; `rs` and `data` stay unchanged.
- `rs` and `data` never change in the same cycle as an `lcd_e` edge.
- FSM states:
  - PWR_WAIT: lasts INIT_WAIT clocks.
  - INIT: writes commands 0x38, 0x0C, 0x06, 0x01 (rs=0), then CLR_WAIT idle clocks.
  - L1_ADDR: writes cmd 0x80.
  - L1_TEXT: writes 16 chars.
  - L2_ADDR: writes cmd 0xC0.
  - L2_TEXT: writes 16 chars.
  - IDLE.
- Refresh start: at the SETUP of L1_ADDR, `mode_sel` is latched into the displayed-mode register (the value 3 is stored as 0). The text is taken from this latched value only.
- Line 1 text (ASCII, space padded to 16 characters):
  - mode 0: "WATCH"
  - mode 1: "STOPWATCH"
  - mode 2: "ALARM SET"
- Line 2 text: "MODE " followed by the ASCII digit of the latched mode ('0'..'2'), padded with spaces to 16 characters.
- IDLE behaviour:
  - `busy`=0, `lcd_e`=0.
  - If normalized `mode_sel` differs from the displayed mode, the next state is L1_ADDR and `busy` rises on that same edge.
- Mode change during a refresh: sets the pending flag and does not disturb the transfer in progress. At the end of L2_TEXT, if the pending flag is set or the mode still differs, the FSM clears the flag and goes directly to L1_ADDR without entering IDLE. `busy` stays 1 throughout.
- A toggle that returns to the displayed value before the refresh ends still causes one extra refresh. This is permitted.
- `rst` asserted mid-transfer: on the next edge the block takes the reset values above, including `lcd_e`=0. It then repeats the full init sequence.
- Character index counter: 4 bits, counts 0..15, and wraps to 0 when leaving a TEXT state.

## Timing
- Cycle 1 is defined as the first rising edge with `rst`=0.
- PWR_WAIT occupies cycles 1..20. The SETUP for 0x38 is cycle 21, and `lcd_e` is first high during cycle 22.
- Init takes 20 + 4×3 + 2 = 34 clocks.
- Refresh is 34 bytes × 3 = 102 clocks.
- `busy` falls at cycle 137 after reset with default parameters.
- Mode change in IDLE: `busy` rises the edge after the change is sampled. The first `lcd_e` pulse follows 1 clock later, and `busy` falls 102 clocks after it rose.
- `lcd_e` high width is exactly 1 clock (1 ms). The minimum gap between `lcd_e` pulses is 2 clocks.

## Test plan
- Reset then hold `mode_sel`=0:
  - `lcd_e` stays 0 for cycles 1..21.
  - Captured byte stream (sampled on `lcd_e` falling) is 0x38, 0x0C, 0x06, 0x01, 0x80, "WATCH" plus 11 spaces (0x20), 0xC0, "MODE 0" plus 10 spaces.
  - `busy` falls at cycle 137.
- In IDLE, set `mode_sel`=1:
  - Captured stream is 0x80, "STOPWATCH" plus 7 spaces, 0xC0, "MODE 1" plus spaces.
  - `busy` is high for exactly 102 clocks.
- `mode_sel`=3 after displaying mode 0: no refresh occurs and `busy` stays 0.
- Change `mode_sel` 0→2 at the 10th character of a refresh:
  - The first refresh completes unchanged.
  - An immediate second refresh writes "ALARM SET" and "MODE 2".
  - `busy` stays high continuously for 204 clocks.
- Assert `rst` for 1 clock while `lcd_e`=1 during L1_TEXT:
  - `lcd_e`=0, `lcd_data`=0x00, `busy`=1 on the next edge.
  - The full init sequence restarts with the 20-clock wait.
- Protocol check throughout all scenarios:
  - `lcd_rw` is always 0.
  - `lcd_data` and `lcd_rs` are stable for the whole cycle before, during and after every `lcd_e`=1 cycle.

Source files
------------

// File: rtl/lcd_mode_display.sv
// -----------------------------------------------------------------------------
// lcd_mode_display
//
// Drives a 16x2 HD44780-compatible text LCD over its 8-bit parallel bus and
// shows a banner for the current watch application mode. After reset the
// block waits for the panel to power up, sends the init commands, then writes
// both lines. From then on both lines are rewritten whenever the (normalized)
// mode differs from the one on screen.
//
// Every byte goes out as a 3-clock SETUP / STROBE / HOLD micro-sequence, so
// rs/data never move in the same cycle as an lcd_e edge. All outputs are
// registered.
//
// Ports
//   clk       in   1  system clock (1 kHz), rising edge
//   rst       in   1  synchronous, active-high reset
//   mode_sel  in   2  0 watch, 1 stopwatch, 2 alarm, 3 shown as watch
//   busy      out  1  high while init or a refresh is in progress
//   lcd_e     out  1  LCD enable strobe (one clock wide)
//   lcd_rs    out  1  0 = command, 1 = character data
//   lcd_rw    out  1  tied 0, write only
//   lcd_data  out  8  LCD data bus
// -----------------------------------------------------------------------------
module lcd_mode_display #(
   parameter int INIT_WAIT = 20,
   parameter int CLR_WAIT  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode_sel,
   output logic       busy,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT,
      INIT_CLR,
      L1_ADDR,
      L1_TEXT,
      L2_ADDR,
      L2_TEXT,
      IDLE
   } state_t;

   typedef enum logic [1:0] {
      PH_SETUP,
      PH_STROBE,
      PH_HOLD
   } phase_t;

   localparam int WAIT_MAX = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1) + 1;

   // Last count value of each wait phase; a zero-length wait still costs the
   // one clock the state itself occupies.
   localparam logic [WAIT_W-1:0] INIT_LAST = WAIT_W'((INIT_WAIT > 1) ? INIT_WAIT - 1 : 0);
   localparam logic [WAIT_W-1:0] CLR_LAST  = WAIT_W'((CLR_WAIT > 1) ? CLR_WAIT - 1 : 0);

   localparam logic [127:0] TXT_WATCH = {"WATCH", {11{8'h20}}};
   localparam logic [127:0] TXT_STOP  = {"STOPWATCH", {7{8'h20}}};
   localparam logic [127:0] TXT_ALARM = {"ALARM SET", {7{8'h20}}};
   localparam logic [127:0] TXT_MODE  = {"MODE ", {11{8'h20}}};

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------
   function automatic phase_t next_phase(input phase_t ph);
      case (ph)
         PH_SETUP:  next_phase = PH_STROBE;
         PH_STROBE: next_phase = PH_HOLD;
         default:   next_phase = PH_SETUP;
      endcase
   endfunction

   // Character 0 is the leftmost one, held in the top byte of the text word.
   function automatic logic [7:0] line1_char(input logic [1:0] md, input logic [3:0] chr);
      logic [127:0] txt;
      case (md)
         2'd1:    txt = TXT_STOP;
         2'd2:    txt = TXT_ALARM;
         default: txt = TXT_WATCH;
      endcase
      line1_char = txt[{~chr, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] line2_char(input logic [1:0] md, input logic [3:0] chr);
      if (chr == 4'd5) begin
         line2_char = 8'h30 + {6'b000000, md};
      end else begin
         line2_char = TXT_MODE[{~chr, 3'b000} +: 8];
      end
   endfunction

   // Returns {rs, data} for the byte sent in the given state/index.
   function automatic logic [8:0] byte_of(input state_t st, input logic [1:0] cmd,
                                          input logic [3:0] chr, input logic [1:0] md);
      case (st)
         INIT: begin
            case (cmd)
               2'd0:    byte_of = 9'h038;   // 8-bit bus, 2 lines, 5x8 font
               2'd1:    byte_of = 9'h00C;   // display on, no cursor
               2'd2:    byte_of = 9'h006;   // increment, no shift
               default: byte_of = 9'h001;   // clear display
            endcase
         end
         L1_ADDR: byte_of = 9'h080;
         L1_TEXT: byte_of = {1'b1, line1_char(md, chr)};
         L2_ADDR: byte_of = 9'h0C0;
         L2_TEXT: byte_of = {1'b1, line2_char(md, chr)};
         default: byte_of = 9'h000;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t            state_q, state_d;
   phase_t            ph_q, ph_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [1:0]        cmd_q, cmd_d;
   logic [3:0]        chr_q, chr_d;
   logic [1:0]        mode_q, mode_d;
   logic              pending_q, pending_d;
   logic              lcd_e_q, lcd_e_d;
   logic              lcd_rs_q, lcd_rs_d;
   logic [7:0]        lcd_data_q, lcd_data_d;
   logic              busy_q, busy_d;

   logic [1:0]        mode_norm;
   logic              mode_diff;
   logic              in_refresh;
   logic              writing_q;
   logic              writing_d;
   logic              byte_done;
   logic              start_refresh;
   logic [8:0]        byte_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PWR_WAIT;
         ph_q       <= PH_SETUP;
         wait_q     <= '0;
         cmd_q      <= 2'd0;
         chr_q      <= 4'd0;
         mode_q     <= 2'd0;
         pending_q  <= 1'b0;
         lcd_e_q    <= 1'b0;
         lcd_rs_q   <= 1'b0;
         lcd_data_q <= 8'h00;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         wait_q     <= wait_d;
         cmd_q      <= cmd_d;
         chr_q      <= chr_d;
         mode_q     <= mode_d;
         pending_q  <= pending_d;
         lcd_e_q    <= lcd_e_d;
         lcd_rs_q   <= lcd_rs_d;
         lcd_data_q <= lcd_data_d;
         busy_q     <= busy_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and registered-output next values
   // ---------------------------------------------------------------------------
   always_comb begin
      mode_norm  = (mode_sel == 2'd3) ? 2'd0 : mode_sel;
      mode_diff  = (mode_norm != mode_q);
      in_refresh = (state_q == L1_ADDR) || (state_q == L1_TEXT) ||
                   (state_q == L2_ADDR) || (state_q == L2_TEXT);
      writing_q  = in_refresh || (state_q == INIT);
      byte_done  = (ph_q == PH_HOLD);

      state_d       = state_q;
      ph_d          = ph_q;
      wait_d        = wait_q;
      cmd_d         = cmd_q;
      chr_d         = chr_q;
      mode_d        = mode_q;
      // A change seen mid-refresh is remembered so the transfer in flight is
      // finished untouched and a fresh refresh follows immediately.
      pending_d     = pending_q | (in_refresh & mode_diff);
      start_refresh = 1'b0;

      if (writing_q) begin
         ph_d = next_phase(ph_q);
      end

      case (state_q)
         PWR_WAIT: begin
            if (wait_q >= INIT_LAST) begin
               state_d = INIT;
               wait_d  = '0;
               cmd_d   = 2'd0;
               ph_d    = PH_SETUP;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         INIT: begin
            if (byte_done) begin
               if (cmd_q == 2'd3) begin
                  if (CLR_WAIT == 0) begin
                     start_refresh = 1'b1;
                  end else begin
                     state_d = INIT_CLR;
                     wait_d  = '0;
                  end
               end else begin
                  cmd_d = cmd_q + 2'd1;
               end
            end
         end
         INIT_CLR: begin
            if (wait_q >= CLR_LAST) begin
               wait_d        = '0;
               start_refresh = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         L1_ADDR: begin
            if (byte_done) begin
               state_d = L1_TEXT;
               chr_d   = 4'd0;
            end
         end
         L1_TEXT: begin
            if (byte_done) begin
               chr_d = chr_q + 4'd1;   // wraps to 0 after the 16th character
               if (chr_q == 4'd15) begin
                  state_d = L2_ADDR;
               end
            end
         end
         L2_ADDR: begin
            if (byte_done) begin
               state_d = L2_TEXT;
               chr_d   = 4'd0;
            end
         end
         L2_TEXT: begin
            if (byte_done) begin
               chr_d = chr_q + 4'd1;
               if (chr_q == 4'd15) begin
                  pending_d = 1'b0;
                  if (pending_q || mode_diff) begin
                     start_refresh = 1'b1;   // back-to-back, busy never drops
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         IDLE: begin
            if (mode_diff) begin
               start_refresh = 1'b1;
            end
         end
         default: begin
            state_d = PWR_WAIT;
            wait_d  = '0;
         end
      endcase

      // The displayed mode is latched as the L1_ADDR setup begins; the text
      // of the whole refresh comes from this copy, never from mode_sel.
      if (start_refresh) begin
         state_d = L1_ADDR;
         ph_d    = PH_SETUP;
         mode_d  = mode_norm;
      end

      writing_d = (state_d == INIT) || (state_d == L1_ADDR) || (state_d == L1_TEXT) ||
                  (state_d == L2_ADDR) || (state_d == L2_TEXT);
      byte_d    = byte_of(state_d, cmd_d, chr_d, mode_d);

      lcd_e_d    = writing_d && (ph_d == PH_STROBE);
      lcd_rs_d   = lcd_rs_q;
      lcd_data_d = lcd_data_q;
      if (writing_d && (ph_d == PH_SETUP)) begin
         lcd_rs_d   = byte_d[8];
         lcd_data_d = byte_d[7:0];
      end
      busy_d = (state_d != IDLE);
   end

   assign busy     = busy_q;
   assign lcd_e    = lcd_e_q;
   assign lcd_rs   = lcd_rs_q;
   assign lcd_rw   = 1'b0;
   assign lcd_data = lcd_data_q;

endmodule

// File: tb/tb_lcd_mode_display.sv
// -----------------------------------------------------------------------------
// Testbench for lcd_mode_display: directed steps plus randomized mode changes,
// checked against a reference built from the banner strings and byte counts.
// -----------------------------------------------------------------------------
module tb_lcd_mode_display;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode_sel;
   logic       busy;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;

   always #5 clk = ~clk;

   lcd_mode_display dut (
      .clk      (clk),
      .rst      (rst),
      .mode_sel (mode_sel),
      .busy     (busy),
      .lcd_e    (lcd_e),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_data (lcd_data)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   bit         prot_en = 1'b0;
   logic       p_e = 1'b0;
   logic       p_rs = 1'b0;
   logic [7:0] p_data = 8'h00;
   logic [8:0] cap_q[$];
   logic [8:0] exp_q[$];
   int         disp;

   task automatic chk(input string tag, input int obs, input int want);
      n_checks++;
      assert (obs === want) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
      end
   endtask

   // One clock: sample at the falling edge, check the bus protocol, capture
   // each strobed byte.
   task automatic step();
      @(negedge clk);
      cyc++;
      chk("rw_zero", int'(lcd_rw), 0);
      if (prot_en) begin
         if (lcd_e) chk("setup_stable", int'({lcd_rs, lcd_data}), int'({p_rs, p_data}));
         if (p_e)   chk("hold_stable", int'({lcd_rs, lcd_data}), int'({p_rs, p_data}));
      end
      if (lcd_e) cap_q.push_back({lcd_rs, lcd_data});
      p_e     = lcd_e;
      p_rs    = lcd_rs;
      p_data  = lcd_data;
      prot_en = 1'b1;
   endtask

   function automatic int norm(input int m);
      return (m == 3) ? 0 : m;
   endfunction

   task automatic add_refresh(input int m);
      string l1;
      string l2;
      if (m == 1)      l1 = "STOPWATCH";
      else if (m == 2) l1 = "ALARM SET";
      else             l1 = "WATCH";
      l2 = $sformatf("MODE %0d", m);
      exp_q.push_back(9'h080);
      for (int i = 0; i < 16; i++) exp_q.push_back((i < l1.len()) ? {1'b1, l1[i]} : 9'h120);
      exp_q.push_back(9'h0C0);
      for (int i = 0; i < 16; i++) exp_q.push_back((i < l2.len()) ? {1'b1, l2[i]} : 9'h120);
   endtask

   task automatic cmp_stream(input string tag);
      int n;
      chk({tag, "_len"}, cap_q.size(), exp_q.size());
      n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_byte%0d", tag, i), int'(cap_q[i]), int'(exp_q[i]));
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      mode_sel = 2'd0;
      prot_en  = 1'b0;
      step();
      chk("rst_lcd_e", int'(lcd_e), 0);
      chk("rst_lcd_rs", int'(lcd_rs), 0);
      chk("rst_lcd_data", int'(lcd_data), 0);
      chk("rst_busy", int'(busy), 1);
      rst = 1'b0;
      cyc = 1;
      cap_q.delete();
      disp = 0;
   endtask

   // From cycle 1 with mode 0: power-up wait, init bytes, first banner.
   task automatic run_init();
      int first_e;
      int done;
      exp_q.delete();
      exp_q.push_back(9'h038);
      exp_q.push_back(9'h00C);
      exp_q.push_back(9'h006);
      exp_q.push_back(9'h001);
      add_refresh(0);
      first_e = -1;
      done    = 0;
      while (cyc < 400) begin
         step();
         if (lcd_e && first_e < 0) first_e = cyc;
         if (!busy) begin
            done = 1;
            break;
         end
      end
      chk("init_done", done, 1);
      chk("init_first_e_cycle", first_e, 22);
      chk("init_busy_fall_cycle", cyc, 137);
      chk("idle_lcd_e", int'(lcd_e), 0);
      cmp_stream("init");
      cap_q.delete();
   endtask

   // Runs until busy has risen and fallen again, or the budget runs out.
   task automatic run_refresh(input int budget, input int chg_at, input int chg_mode,
                              output int hi, output int fb, output int fe, output int done);
      hi   = 0;
      fb   = -1;
      fe   = -1;
      done = 0;
      for (int n = 1; n <= budget; n++) begin
         step();
         if (busy) begin
            hi++;
            if (fb < 0) fb = n;
         end
         if (lcd_e && fe < 0) fe = n;
         if (chg_at > 0 && lcd_e && cap_q.size() == chg_at) mode_sel = 2'(chg_mode);
         if (fb >= 0 && !busy) begin
            done = 1;
            break;
         end
      end
   endtask

   initial begin
      int hi, fb, fe, done;
      int m, m2, nm, n2, gap, chg_at, reached;

      do_reset();
      run_init();

      // Mode change in IDLE
      exp_q.delete(); cap_q.delete();
      add_refresh(1);
      mode_sel = 2'd1;
      run_refresh(300, 0, 0, hi, fb, fe, done);
      chk("m1_done", done, 1);
      chk("m1_busy_width", hi, 102);
      chk("m1_busy_rise", fb, 1);
      chk("m1_first_e", fe, 2);
      cmp_stream("m1");
      disp = 1;

      // Change to 2 at the 10th character of the refresh showing 0
      exp_q.delete(); cap_q.delete();
      add_refresh(0);
      add_refresh(2);
      mode_sel = 2'd0;
      run_refresh(600, 11, 2, hi, fb, fe, done);
      chk("chg_done", done, 1);
      chk("chg_busy_width", hi, 204);
      chk("chg_busy_rise", fb, 1);
      cmp_stream("chg");
      disp = 2;

      exp_q.delete(); cap_q.delete();
      add_refresh(0);
      mode_sel = 2'd0;
      run_refresh(300, 0, 0, hi, fb, fe, done);
      chk("m0_busy_width", hi, 102);
      cmp_stream("m0");
      disp = 0;

      // 3 is shown as 0: nothing to do
      exp_q.delete(); cap_q.delete();
      mode_sel = 2'd3;
      run_refresh(30, 0, 0, hi, fb, fe, done);
      chk("m3_busy_width", hi, 0);
      chk("m3_busy_now", int'(busy), 0);
      cmp_stream("m3");

      // Randomized mode changes, some of them mid-refresh
      for (int it = 0; it < 10; it++) begin
         m   = $urandom_range(0, 3);
         gap = $urandom_range(0, 4);
         repeat (gap) step();
         nm = norm(m);
         exp_q.delete(); cap_q.delete();
         mode_sel = 2'(m);
         if (nm == disp) begin
            run_refresh(30, 0, 0, hi, fb, fe, done);
            chk($sformatf("rnd%0d_quiet", it), hi, 0);
            cmp_stream($sformatf("rnd%0d", it));
         end else if ($urandom_range(0, 2) == 0) begin
            do m2 = $urandom_range(0, 3); while (norm(m2) == nm);
            n2     = norm(m2);
            chg_at = $urandom_range(1, 33);
            add_refresh(nm);
            add_refresh(n2);
            run_refresh(600, chg_at, m2, hi, fb, fe, done);
            chk($sformatf("rnd%0d_done", it), done, 1);
            chk($sformatf("rnd%0d_busy_width2", it), hi, 204);
            cmp_stream($sformatf("rnd%0d", it));
            disp = n2;
         end else begin
            add_refresh(nm);
            run_refresh(300, 0, 0, hi, fb, fe, done);
            chk($sformatf("rnd%0d_done", it), done, 1);
            chk($sformatf("rnd%0d_busy_width", it), hi, 102);
            chk($sformatf("rnd%0d_first_e", it), fe, 2);
            cmp_stream($sformatf("rnd%0d", it));
            disp = nm;
         end
      end

      // Reset during an L1_TEXT strobe, then the whole init again
      cap_q.delete();
      mode_sel = (disp == 1) ? 2'd2 : 2'd1;
      reached  = 0;
      for (int n = 0; n < 200; n++) begin
         step();
         if (lcd_e && cap_q.size() == 5) begin
            reached = 1;
            break;
         end
      end
      chk("l1_text_strobe_reached", reached, 1);
      do_reset();
      run_init();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
